// File: rtl/vec_regfile_fill.sv
// Vector register file with two async read ports, lane-masked direct write and a beat-serial fill engine.
// Optional macro VRF_BYPASS_EN adds same-cycle write-to-read forwarding on rd1/rd2.
module vec_regfile_fill #(
  parameter int NREGS = 16,
  parameter int LANES = 16,
  parameter int LANEW = 8,
  parameter int AW    = $clog2(NREGS),
  parameter int BEATW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  output logic [LANES*LANEW-1:0] rd1,
  output logic [LANES*LANEW-1:0] rd2,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [LANES-1:0]       wmask,
  input  logic [LANES*LANEW-1:0] wd,
  input  logic                   fill_start,
  input  logic [AW-1:0]          fill_reg,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [BEATW-1:0]       fill_data,
  output logic                   fill_done,
  output logic [NREGS-1:0]       busy
);

  localparam int VW    = LANES * LANEW;
  localparam int BEATS = VW / BEATW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t          state;
  logic [AW-1:0]   dst;
  logic [CW-1:0]   cnt;
  logic [VW-1:0]   shadow;
  logic [VW-1:0]   vrf [NREGS];
  logic            commit;
  logic            beat;

  assign commit = (state == COMMIT);
  assign beat   = fill_ready && fill_valid;

  function automatic logic [VW-1:0] lane_merge(input logic [VW-1:0]    old_v,
                                               input logic [VW-1:0]    new_v,
                                               input logic [LANES-1:0] mask);
    logic [VW-1:0] r;
    r = old_v;
    for (int i = 0; i < LANES; i++)
      if (mask[i]) r[i*LANEW +: LANEW] = new_v[i*LANEW +: LANEW];
    return r;
  endfunction

  // fill_ready mirrors FILL; fill_done is set on entry to COMMIT so it is high for that cycle only
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dst        <= '0;
      cnt        <= '0;
      busy       <= '0;
      fill_ready <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            dst            <= fill_reg;
            cnt            <= '0;
            busy[fill_reg] <= 1'b1;
            fill_ready     <= 1'b1;
            state          <= FILL;
          end
        end
        FILL: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(BEATS - 1)) begin
              fill_ready <= 1'b0;
              fill_done  <= 1'b1;
              state      <= COMMIT;
            end
          end
        end
        COMMIT: begin
          busy[dst] <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow is pure data; a reset simply leaves stale beats that the next fill overwrites
  always_ff @(posedge clk) begin
    if (beat) shadow[cnt*BEATW +: BEATW] <= fill_data;
  end

  // Commit beats a colliding direct write to the same register on every lane
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) vrf[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (commit && dst == AW'(r))
          vrf[r] <= shadow;
        else if (we && wa == AW'(r))
          vrf[r] <= lane_merge(vrf[r], wd, wmask);
      end
    end
  end

`ifdef VRF_BYPASS_EN
  function automatic logic [VW-1:0] fwd(input logic [AW-1:0] addr,
                                        input logic [VW-1:0] stored);
    if (commit && dst == addr)
      return shadow;
    else if (we && wa == addr)
      return lane_merge(stored, wd, wmask);
    else
      return stored;
  endfunction

  assign rd1 = fwd(ra1, vrf[ra1]);
  assign rd2 = fwd(ra2, vrf[ra2]);
`else
  assign rd1 = vrf[ra1];
  assign rd2 = vrf[ra2];
`endif

endmodule

// File: tb/tb_vec_regfile_fill.sv
// Scoreboard bench for vec_regfile_fill: expected fill vectors are queued at start and popped at fill_done.
module tb_vec_regfile_fill;

  localparam int NREGS = 16;
  localparam int LANES = 16;
  localparam int LANEW = 8;
  localparam int AW    = 4;
  localparam int BEATW = 32;
  localparam int VW    = LANES * LANEW;
  localparam int BEATS = VW / BEATW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [AW-1:0]    ra1 = '0, ra2 = '0;
  logic [VW-1:0]    rd1, rd2;
  logic             we = 1'b0;
  logic [AW-1:0]    wa = '0;
  logic [LANES-1:0] wmask = '0;
  logic [VW-1:0]    wd = '0;
  logic             fill_start = 1'b0;
  logic [AW-1:0]    fill_reg = '0;
  logic             fill_valid = 1'b0;
  logic             fill_ready;
  logic [BEATW-1:0] fill_data = '0;
  logic             fill_done;
  logic [NREGS-1:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [VW-1:0] sb[$];

  int            done_t, done_cnt, busy_cnt, ready_bad, other_busy;
  logic [VW-1:0] got1, got2;

  vec_regfile_fill #(.NREGS(NREGS), .LANES(LANES), .LANEW(LANEW), .AW(AW), .BEATW(BEATW)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wmask(wmask), .wd(wd),
    .fill_start(fill_start), .fill_reg(fill_reg), .fill_valid(fill_valid),
    .fill_ready(fill_ready), .fill_data(fill_data), .fill_done(fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1);
  end

  function automatic logic [VW-1:0] mkvec(input logic [7:0] base);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*LANEW +: LANEW] = base + 8'(i);
    return v;
  endfunction

  function automatic logic [VW-1:0] splat(input logic [7:0] b);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*LANEW +: LANEW] = b;
    return v;
  endfunction

  // Drives one fill; optional stall before beat stall_k, direct write in COMMIT, spurious start, early abort
  task automatic do_fill(input logic [AW-1:0] dst, input logic [7:0] base, input int stall_k,
                         input int stall_n, input bit collide, input logic [AW-1:0] cwa,
                         input bit spur, input int abort_k);
    logic [VW-1:0] v;
    int k, stalled;
    v = mkvec(base);
    if (abort_k < 0) sb.push_back(v);
    done_t = -1; done_cnt = 0; busy_cnt = 0; ready_bad = 0; other_busy = 0;
    got1 = 'x; got2 = 'x;
    fill_start = 1'b1; fill_reg = dst; fill_valid = 1'b0;
    @(posedge clk); #1;
    fill_start = 1'b0;
    k = 0; stalled = 0;
    for (int t = 1; t <= 40; t++) begin
      if (abort_k >= 0 && k >= abort_k) break;
      fill_valid = (k < BEATS) && !(k == stall_k && stalled < stall_n);
      fill_data  = (k < BEATS) ? v[k*BEATW +: BEATW] : '0;
      fill_start = spur && (t == 2);
      fill_reg   = (spur && t == 2) ? dst ^ AW'(1) : dst;
      ra1 = dst; ra2 = cwa;
      we    = collide && (k == BEATS) && (done_t < 0);
      wa    = cwa; wmask = '1; wd = splat(8'hAA);
      @(negedge clk);
      if (busy[dst]) busy_cnt++;
      if ((busy & ~(NREGS'(1) << dst)) != '0) other_busy++;
      if (fill_ready !== (k < BEATS)) ready_bad++;
      if (fill_done) begin
        if (done_t < 0) done_t = t;
        done_cnt++;
      end
      if (done_t >= 0 && t == done_t + 1) begin
        got1 = rd1; got2 = rd2;
        break;
      end
      if (fill_valid && fill_ready) k++;
      else if (!fill_valid && k == stall_k) stalled++;
      @(posedge clk); #1;
    end
    we = 1'b0; fill_valid = 1'b0; fill_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (fill_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", fill_ready); end
    n_cmp++; if (fill_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", fill_done); end
    n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL reset_busy: got %h want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      ra1 = AW'(r); ra2 = AW'(NREGS - 1 - r);
      @(negedge clk);
      n_cmp++; if (rd1 !== '0) begin n_bad++; $display("FAIL reset_rd1 r%0d: got %h want 0", r, rd1); end
      n_cmp++; if (rd2 !== '0) begin n_bad++; $display("FAIL reset_rd2 r%0d: got %h want 0", NREGS-1-r, rd2); end
      @(posedge clk); #1;
    end
    n_cmp++; if (busy !== '0 || fill_ready !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got busy=%h ready=%b want 0/0", busy, fill_ready); end
  endtask

  task automatic test_masked_write;
    logic [VW-1:0] exp;
    exp = '0;
    for (int i = 0; i < 8; i++) exp[i*LANEW +: LANEW] = 8'h10 + 8'(i);
    we = 1'b1; wa = 3; wd = mkvec(8'h10); wmask = 16'h00FF; ra1 = 3; ra2 = 4;
    @(negedge clk);
`ifdef VRF_BYPASS_EN
    n_cmp++; if (rd1 !== exp) begin n_bad++; $display("FAIL mw_bypass: got %h want %h", rd1, exp); end
`else
    n_cmp++; if (rd1 !== '0) begin n_bad++; $display("FAIL mw_old_value: got %h want 0", rd1); end
`endif
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    n_cmp++; if (rd1 !== exp) begin n_bad++; $display("FAIL mw_lanes: got %h want %h", rd1, exp); end
    n_cmp++; if (rd2 !== '0) begin n_bad++; $display("FAIL mw_other_reg: got %h want 0", rd2); end
    @(posedge clk); #1;
    we = 1'b1; wd = splat(8'hFF); wmask = '0;
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    n_cmp++; if (rd1 !== exp) begin n_bad++; $display("FAIL mw_zero_mask: got %h want %h", rd1, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [VW-1:0] exp;
    do_fill(5, 8'h00, -1, 0, 1'b0, 4'd6, 1'b1, -1);
    n_cmp++; if (done_t !== 5) begin n_bad++; $display("FAIL b2b_done_latency: got %0d want 5", done_t); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt !== 5) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 5", busy_cnt); end
    n_cmp++; if (ready_bad !== 0) begin n_bad++; $display("FAIL b2b_ready: got %0d bad cycles want 0", ready_bad); end
    n_cmp++; if (other_busy !== 0) begin n_bad++; $display("FAIL b2b_ignored_start: got %0d cycles with foreign busy want 0", other_busy); end
    exp = sb.pop_front();
    n_cmp++; if (got1 !== exp) begin n_bad++; $display("FAIL b2b_data: got %h want %h", got1, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_collision;
    logic [VW-1:0] exp;
    do_fill(5, 8'h40, 2, 3, 1'b1, 4'd5, 1'b0, -1);
    n_cmp++; if (done_t !== 8) begin n_bad++; $display("FAIL stall_done_latency: got %0d want 8", done_t); end
    n_cmp++; if (busy_cnt !== 8) begin n_bad++; $display("FAIL stall_busy_cycles: got %0d want 8", busy_cnt); end
    n_cmp++; if (ready_bad !== 0) begin n_bad++; $display("FAIL stall_ready: got %0d bad cycles want 0", ready_bad); end
    exp = sb.pop_front();
    n_cmp++; if (got1 !== exp) begin n_bad++; $display("FAIL stall_collision_data: got %h want %h", got1, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fill;
    logic [VW-1:0] exp;
    bit saw_done;
    do_fill(5, 8'h60, -1, 0, 1'b0, 4'd5, 1'b0, 2);
    n_cmp++; if (busy[5] !== 1'b1) begin n_bad++; $display("FAIL midfill_busy_before: got %b want 1", busy[5]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ra1 = 5; ra2 = 3;
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (fill_done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL midfill_no_done: got %b want 0", saw_done); end
    n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL midfill_busy: got %h want 0", busy); end
    n_cmp++; if (fill_ready !== 1'b0) begin n_bad++; $display("FAIL midfill_ready: got %b want 0", fill_ready); end
    n_cmp++; if (rd1 !== '0) begin n_bad++; $display("FAIL midfill_r5: got %h want 0", rd1); end
    n_cmp++; if (rd2 !== '0) begin n_bad++; $display("FAIL midfill_r3: got %h want 0", rd2); end
    @(posedge clk); #1;
    do_fill(5, 8'h80, -1, 0, 1'b1, 4'd7, 1'b0, -1);
    n_cmp++; if (done_t !== 5) begin n_bad++; $display("FAIL refill_done_latency: got %0d want 5", done_t); end
    exp = sb.pop_front();
    n_cmp++; if (got1 !== exp) begin n_bad++; $display("FAIL refill_data: got %h want %h", got1, exp); end
    n_cmp++; if (got2 !== splat(8'hAA)) begin n_bad++; $display("FAIL refill_side_write_r7: got %h want %h", got2, splat(8'hAA)); end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass;
    ra1 = 3; ra2 = 3;
    we = 1'b1; wa = 3; wmask = '1; wd = splat(8'h55);
    @(negedge clk);
`ifdef VRF_BYPASS_EN
    n_cmp++; if (rd1 !== splat(8'h55)) begin n_bad++; $display("FAIL bypass_rd1: got %h want %h", rd1, splat(8'h55)); end
`else
    n_cmp++; if (rd1 !== '0) begin n_bad++; $display("FAIL nobypass_rd1: got %h want 0", rd1); end
`endif
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    n_cmp++; if (rd2 !== splat(8'h55)) begin n_bad++; $display("FAIL bypass_after_write: got %h want %h", rd2, splat(8'h55)); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_masked_write;
    test_back_to_back;
    test_stall_collision;
    test_reset_mid_fill;
    test_bypass;
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_regfile_fill.md
# vec_regfile_fill

Parametrised vector register file for the SIMD FIR datapath: `NREGS` registers of `LANES` lanes × `LANEW` bits, two asynchronous read ports, a lane-masked direct write port, and a serial fill engine. The fill engine assembles a full vector from narrow `BEATW`-bit beats over a valid/ready handshake, then commits it atomically. A per-register busy scoreboard lets the issue logic stall on registers with a fill in flight. The block sits between the decode/execute stages and the sample-memory load path.

## Interface
- `NREGS`, 16, number of vector registers
- `LANES`, 16, lanes per register
- `LANEW`, 8, bits per lane
- `AW`, `$clog2(NREGS)`, register address width
- `BEATW`, 32, fill beat width; `LANES*LANEW` must be an integer multiple of `BEATW`
- Derived: `VW = LANES*LANEW`; `BEATS = VW/BEATW`
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `ra1`, `ra2`  in  AW  read addresses
- `rd1`, `rd2`  out  VW  read data; lane i = bits `[i*LANEW +: LANEW]`
- `we`  in  1  direct write enable
- `wa`  in  AW  direct write address
- `wmask`  in  LANES  per-lane write enable for direct writes
- `wd`  in  VW  direct write data
- `fill_start`  in  1  request a fill; sampled only in IDLE
- `fill_reg`  in  AW  destination register, sampled with `fill_start`
- `fill_valid`  in  1  beat valid
- `fill_ready`  out  1  engine accepts a beat
- `fill_data`  in  BEATW  beat payload
- `fill_done`  out  1  one-cycle pulse in the COMMIT cycle
- `busy`  out  NREGS  bit r is high while register r has a fill pending

## Operation
- **Storage and reads:** All registers are zero after reset. Reads are combinational: `rd1 = vrf[ra1]` and `rd2 = vrf[ra2]`.
- **Direct write:** When `we` is high, lane i of `vrf[wa]` takes lane i of `wd` for every i with `wmask[i]=1`. Lanes with `wmask[i]=0` are unchanged. `wmask=0` is a no-op.
- **Fill FSM states:** IDLE, FILL, COMMIT.
  - IDLE, `fill_start=1`: latch `fill_reg` into `dst`, clear beat counter `cnt`, set `busy[dst]`, go to FILL.
  - FILL: `fill_ready=1`. On `fill_valid & fill_ready`, write `fill_data` into shadow bits `[cnt*BEATW +: BEATW]` and increment `cnt`. On the handshake with `cnt==BEATS-1`, go to COMMIT.
  - COMMIT: write the entire shadow buffer into `vrf[dst]`, pulse `fill_done`, clear `busy[dst]` on the same edge, return to IDLE.
- **Beat order:** beat 0 carries the lowest lanes.
- **Ignored start:** `fill_start` is ignored outside IDLE.
- **Stalled source:** `fill_valid` low in FILL stalls the engine indefinitely, with no timeout.
- **Commit/direct-write collision:** In the COMMIT cycle, if `we=1` and `wa==dst`, the commit wins for all lanes and the direct write is dropped. A direct write to any other register proceeds in the same cycle.
- **Writes during FILL:** Direct writes to `dst` during FILL are performed but are overwritten by the commit. Issue logic must consult `busy` to avoid this.
- **Reset mid-fill:** Return to IDLE, clear `busy` and `cnt`, discard the shadow buffer, no commit, no `fill_done`. Register contents are zeroed.

## Timing
- **Reset values:** `fill_ready=0`, `fill_done=0`, `busy=0`; `rd1`/`rd2` read zero.
- **Fill latency:** `fill_start` at edge N puts FILL at N+1. With back-to-back beats, the last beat is accepted at N+BEATS and COMMIT occurs in cycle N+BEATS+1. `fill_done` is high for exactly that cycle, and the data is readable from the following cycle. Minimum fill is `BEATS+2` cycles from start to readable.
- **busy:** `busy[dst]` rises the cycle after start and is low in the cycle after COMMIT.
- **Next start:** a new `fill_start` is accepted in the IDLE cycle after COMMIT, not in COMMIT itself.
- **Write-to-read latency:** Direct writes are visible on `rd*` the cycle after the edge, unless bypass is compiled in.

## Configuration
- **`VRF_BYPASS_EN` defined:** same-cycle write-to-read forwarding.
  - If `we` and `wa==raX`, masked lanes of `rdX` show `wd`.
  - In COMMIT with `dst==raX`, `rdX` shows the whole shadow buffer, and commit takes precedence over the direct write.
- **`VRF_BYPASS_EN` undefined:** `rdX` always shows the stored contents, i.e. the old value during a write cycle.

## Test plan
- **Reset then read:** reset, then read all 16 registers → every `rd1`/`rd2` = 0, `busy=0`, `fill_ready=0`.
- **Masked write:** write `wd` = lanes i=0..15 holding 0x10+i, `wa=3`, `wmask=0x00FF`, into a zeroed register → next cycle lanes 0–7 = 0x10..0x17, lanes 8–15 = 0.
- **Back-to-back fill:** `fill_start`, `fill_reg=5`, four beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with `fill_valid` always high → `fill_done` 5 cycles after start, lane i of r5 = i, `busy[5]` high for exactly 5 cycles.
- **Stalled fill with collision:** same fill with `fill_valid` low for 3 cycles between beats 1 and 2, plus `we=1 wa=5 wmask=0xFFFF wd=all 0xAA` in the COMMIT cycle → r5 holds the fill data, and `fill_ready` is low only outside FILL.
- **Reset mid-fill:** assert `rst` after 2 of 4 beats → no `fill_done`, `busy=0`, r5 = 0, and a new fill started afterwards completes normally.
- **Bypass build:** with `VRF_BYPASS_EN`, set `ra1=3` and write 0x55 to all lanes of r3 → `rd1`=0x55 per lane in the write cycle. Without the macro, `rd1` shows the old value in that cycle.
